// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling with a 3-sample
// majority vote at mid-bit, and a one-entry valid/ready holding register.
module uart_rx #(
    parameter int CLK_FREQ = 75_000_000,
    parameter int BAUD     = 115200,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = (CLK_FREQ + BAUD * OVS / 2) / (BAUD * OVS);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVS);

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [OW-1:0] OS_A     = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OS_B     = OW'(OVS / 2);
    localparam logic [OW-1:0] OS_C     = OW'(OVS / 2 + 1);
    localparam logic [OW-1:0] OS_END   = OW'(OVS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic            rx_meta, rx_s, rx_d;
    logic [PW-1:0]   pre_cnt;
    logic [OW-1:0]   os_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            samp_a, samp_b;
    logic            fall, tick, decide, bit_end, maj;
    logic            start_go, to_data, shift_en, bit_inc, good, ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall    = rx_d & ~rx_s;
    assign tick    = (pre_cnt == PRE_LAST);
    assign decide  = tick && (os_cnt == OS_C);
    assign bit_end = tick && (os_cnt == OS_END);
    // Third vote is the live synchronised line at the decision point.
    assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        to_data    = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        good       = 1'b0;
        ferr       = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    start_go   = 1'b1;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                    to_data    = 1'b1;
                end
            end
            DATA: begin
                shift_en = decide;
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                if (decide) begin
                    state_next = IDLE;
                    good       = maj;
                    ferr       = ~maj;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            samp_a  <= 1'b0;
            samp_b  <= 1'b0;
        end else begin
            if (start_go || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (start_go) begin
                os_cnt <= '0;
            end else if (tick && state != IDLE) begin
                os_cnt <= (os_cnt == OS_END) ? '0 : os_cnt + 1'b1;
            end
            if (tick && os_cnt == OS_A) samp_a <= rx_s;
            if (tick && os_cnt == OS_B) samp_b <= rx_s;
            if (to_data) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) shreg <= {maj, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= good && valid && !ready;
            if (good && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clk per bit: expected bytes are queued
// as frames are sent and matched against bytes accepted on valid&&ready.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int compared   = 0;
    int mismatches = 0;
    int vld_cyc    = 0;
    int err_cyc    = 0;
    int ovr_cyc    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Stimulus changes on negedge; the monitor samples 1 ns later.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (valid) vld_cyc++;
            if (valid && ready) act_q.push_back(data);
            if (frame_err) err_cyc++;
            if (overrun) ovr_cyc++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        compared++; if (data !== 8'h00) begin mismatches++; $display("FAIL reset_data got %02h required 00", data); end
        compared++; if (valid !== 1'b0) begin mismatches++; $display("FAIL reset_valid got %b required 0", valid); end
        compared++; if (frame_err !== 1'b0) begin mismatches++; $display("FAIL reset_frame_err got %b required 0", frame_err); end
        compared++; if (overrun !== 1'b0) begin mismatches++; $display("FAIL reset_overrun got %b required 0", overrun); end
    endtask

    task automatic test_single();
        int v0, e0, o0;
        logic [7:0] a, e;
        v0 = vld_cyc; e0 = err_cyc; o0 = ovr_cyc;
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (8) @(negedge clk);
        compared++; if (act_q.size() !== 1) begin mismatches++; $display("FAIL single_count got %0d required 1", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            compared++; if (a !== e) begin mismatches++; $display("FAIL single_data got %02h required %02h", a, e); end
        end
        compared++; if (vld_cyc - v0 !== 1) begin mismatches++; $display("FAIL single_valid_cycles got %0d required 1", vld_cyc - v0); end
        compared++; if (err_cyc - e0 !== 0) begin mismatches++; $display("FAIL single_frame_err got %0d required 0", err_cyc - e0); end
        compared++; if (ovr_cyc - o0 !== 0) begin mismatches++; $display("FAIL single_overrun got %0d required 0", ovr_cyc - o0); end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_glitch();
        int v0, e0;
        logic [7:0] a, e;
        v0 = vld_cyc; e0 = err_cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        compared++; if (vld_cyc - v0 !== 0) begin mismatches++; $display("FAIL glitch_valid got %0d required 0", vld_cyc - v0); end
        compared++; if (err_cyc - e0 !== 0) begin mismatches++; $display("FAIL glitch_frame_err got %0d required 0", err_cyc - e0); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        compared++; if (act_q.size() !== 1) begin mismatches++; $display("FAIL glitch_next_count got %0d required 1", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            compared++; if (a !== e) begin mismatches++; $display("FAIL glitch_next_data got %02h required %02h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_frame_err();
        int v0, e0;
        logic [7:0] a, e;
        v0 = vld_cyc; e0 = err_cyc;
        send_frame(8'h3C, 1'b0);
        repeat (16) @(negedge clk);
        compared++; if (err_cyc - e0 !== 1) begin mismatches++; $display("FAIL ferr_cycles got %0d required 1", err_cyc - e0); end
        compared++; if (vld_cyc - v0 !== 0) begin mismatches++; $display("FAIL ferr_valid got %0d required 0", vld_cyc - v0); end
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        compared++; if (act_q.size() !== 1) begin mismatches++; $display("FAIL ferr_next_count got %0d required 1", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            compared++; if (a !== e) begin mismatches++; $display("FAIL ferr_next_data got %02h required %02h", a, e); end
        end
        compared++; if (err_cyc - e0 !== 1) begin mismatches++; $display("FAIL ferr_after_good got %0d required 1", err_cyc - e0); end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_overrun();
        int o0;
        logic [7:0] a, e;
        o0 = ovr_cyc;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (8) @(negedge clk);
        compared++; if (valid !== 1'b1) begin mismatches++; $display("FAIL ovr_valid got %b required 1", valid); end
        compared++; if (data !== 8'h11) begin mismatches++; $display("FAIL ovr_data got %02h required 11", data); end
        compared++; if (ovr_cyc - o0 !== 1) begin mismatches++; $display("FAIL ovr_pulses got %0d required 1", ovr_cyc - o0); end
        compared++; if (act_q.size() !== 0) begin mismatches++; $display("FAIL ovr_early_accept got %0d required 0", act_q.size()); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (valid !== 1'b0) begin mismatches++; $display("FAIL ovr_drain_valid got %b required 0", valid); end
        compared++; if (data !== 8'h11) begin mismatches++; $display("FAIL ovr_drain_data got %02h required 11", data); end
        compared++; if (act_q.size() !== 1) begin mismatches++; $display("FAIL ovr_accept_count got %0d required 1", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            compared++; if (a !== e) begin mismatches++; $display("FAIL ovr_accept_data got %02h required %02h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_back_to_back();
        int v0, e0, o0;
        logic [7:0] a, e;
        v0 = vld_cyc; e0 = err_cyc; o0 = ovr_cyc;
        ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (8) @(negedge clk);
        compared++; if (act_q.size() !== 2) begin mismatches++; $display("FAIL b2b_count got %0d required 2", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            compared++; if (a !== e) begin mismatches++; $display("FAIL b2b_data got %02h required %02h", a, e); end
        end
        compared++; if (vld_cyc - v0 !== 2) begin mismatches++; $display("FAIL b2b_valid_cycles got %0d required 2", vld_cyc - v0); end
        compared++; if (err_cyc - e0 + ovr_cyc - o0 !== 0) begin mismatches++; $display("FAIL b2b_errors got %0d required 0", err_cyc - e0 + ovr_cyc - o0); end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_reset_abort();
        int v0, e0;
        logic [7:0] b;
        logic [7:0] a, e;
        b = 8'hC3;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = b[3];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        compared++; if (data !== 8'h00) begin mismatches++; $display("FAIL abort_reset_data got %02h required 00", data); end
        rst_n = 1'b1;
        v0 = vld_cyc; e0 = err_cyc;
        repeat (200) @(negedge clk);
        compared++; if (vld_cyc - v0 !== 0) begin mismatches++; $display("FAIL abort_valid got %0d required 0", vld_cyc - v0); end
        compared++; if (err_cyc - e0 !== 0) begin mismatches++; $display("FAIL abort_frame_err got %0d required 0", err_cyc - e0); end
        ready = 1'b0;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        compared++; if (valid !== 1'b1) begin mismatches++; $display("FAIL abort_next_valid got %b required 1", valid); end
        compared++; if (data !== 8'h7E) begin mismatches++; $display("FAIL abort_next_data got %02h required 7e", data); end
        ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (act_q.size() !== 1) begin mismatches++; $display("FAIL abort_accept_count got %0d required 1", act_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            compared++; if (a !== e) begin mismatches++; $display("FAIL abort_accept_data got %02h required %02h", a, e); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    initial begin
        rx    = 1'b1;
        ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatches);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Byte-level UART receiver for the inter-board game link. It is the receive end of the serial line whose transmit end drives the board's `tx` pin.
- Synchronises the asynchronous `rx` pin and samples it at 16x oversampling, using a 3-sample majority vote at mid-bit.
- Validates start and stop bits.
- Presents each received byte through a one-entry valid/ready holding register to the game-state logic in the 75 MHz domain.

Parameters:
- CLK_FREQ, 75_000_000: clk frequency in Hz.
- BAUD, 115200: line bit rate.
- OVS, 16: oversampling factor; must be even and >= 8.
- DIV (localparam): (CLK_FREQ + BAUD*OVS/2) / (BAUD*OVS), i.e. rounded; 41 with the defaults; must be >= 1.

Ports:
- clk  in  1  system clock (75 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, asynchronous, idle high.
- data  out  8  received byte, valid while valid=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts data when valid&&ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.

Behaviour:
- Reset is asynchronous and active-low; all flops clear on rst_n=0. Reset values:
  - data=0, valid=0, frame_err=0, overrun=0.
  - state=IDLE.
  - synchroniser flops=1 (line idle).
  - all counters=0.
- Synchroniser: 2 flops on rx, giving rx_s. A falling edge is detected against one extra registered copy of rx_s.
- Tick prescaler: counts 0..DIV-1 and emits tick when the count equals DIV-1. It is cleared on entry to START.
- Oversample counter os_cnt: 0..OVS-1, advanced on tick. Samples are taken at os_cnt = OVS/2-1, OVS/2 and OVS/2+1. The majority of the three is decided at os_cnt=OVS/2+1.
- FSM:
  - IDLE: on an rx_s falling edge, go to START; clear os_cnt and the prescaler.
  - START: at the decision point, if the majority is 1 (false start or glitch), return to IDLE. If the majority is 0, continue to the bit end (os_cnt=OVS-1, tick), then go to DATA with bit_cnt=0.
  - DATA: at each decision point, shift the majority into shreg, LSB first. At the bit end, increment bit_cnt. After bit_cnt=7, go to STOP.
  - STOP: at the decision point, return to IDLE immediately (do not wait for the bit end), so that a back-to-back start edge is caught.
    - Majority 1: the frame is good and shreg is offered to the holding register.
    - Majority 0: pulse frame_err for 1 cycle; the byte is discarded and valid is unaffected.
- Holding register:
  - valid&&ready with no new byte: valid goes to 0 next cycle; data keeps its value.
  - Good frame and (valid=0 or ready=1) in the same cycle: data<=shreg and valid<=1 next cycle. A simultaneous accept plus load leaves valid=1 with the new data.
  - Good frame while valid=1 and ready=0: the new byte is dropped, data/valid are unchanged, and overrun pulses for 1 cycle.
- Latency: valid rises exactly 1 clk after the STOP decision tick. Input to sampling delay is 2 clk (synchroniser).
- A line held low (break) gives START, DATA all 0, then frame_err. The receiver then stays in IDLE until the next falling edge, i.e. after rx returns high.
- Asserting rst_n=0 mid-frame aborts the frame. No valid or frame_err is produced for the partial frame.
- ready is ignored while valid=0.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD=100_000, OVS=16, giving DIV=1 and 16 clk per bit.
1. Send 0xA5 (8N1) with ready=1 -> one valid pulse (1 cycle, because ready=1) with data=0xA5; frame_err=0; overrun=0.
2. Drive rx low for 3 clk, then high -> FSM returns to IDLE; no valid and no frame_err. A following 0x3C frame is received correctly.
3. Send 0x3C with the stop bit forced to 0 -> frame_err pulses for exactly 1 cycle; valid stays 0; the next correct 0x5A frame is received.
4. Hold ready=0 and send 0x11 then 0x22 back-to-back -> valid=1 with data=0x11 and one overrun pulse at the second STOP. After ready=1 for one cycle, valid=0 and data remains 0x11.
5. With ready=1, send 0x00 then 0xFF back-to-back, with the stop bit exactly 16 clk -> two valid beats: 0x00 then 0xFF; no errors.
6. Assert rst_n=0 during bit 3 of 0xC3, release, then send 0x7E -> no output from the aborted frame; then data=0x7E and valid=1.
